// File: rtl/ysyx_22050612_mem_responder_if.sv
// rtl/ysyx_22050612_mem_responder_if.sv - request/response channel bundle between LSU and memory responder
interface ysyx_22050612_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [7:0]  req_wmask;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/ysyx_22050612_mem_responder.sv
// rtl/ysyx_22050612_mem_responder.sv - fixed-latency 64-bit memory responder, one outstanding request
// Optional YSYX_22050612_MEM_RAND_LAT_EN adds 0..3 LFSR-driven extra wait cycles per request.
module ysyx_22050612_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [63:0] BASE_ADDR = 64'h80000000,
  parameter int          LATENCY   = 2
) (
  input logic                           clk,
  input logic                           rst_n,
  ysyx_22050612_mem_responder_if.slave  bus
);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam int          CNT_W = $clog2(LATENCY + 4) + 1;
  localparam logic [63:0] LIMIT = BASE_ADDR + 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] load_cnt;
  logic             wen_q;
  logic [63:0]      addr_q;
  logic [63:0]      wdata_q;
  logic [7:0]       wmask_q;
  logic [63:0]      mem [DEPTH];

  logic [63:0]      offset;
  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             access;
  logic             accept;
  logic             unused_bits;

  assign offset      = addr_q - BASE_ADDR;
  assign idx         = offset[IDX_W+2:3];
  // Full-width compare so addresses below BASE_ADDR cannot wrap into the array.
  assign in_range    = (addr_q >= BASE_ADDR) && (addr_q < LIMIT);
  assign access      = (state == WAIT) && (counter == '0);
  assign accept      = (state == IDLE) && bus.req_valid && bus.req_ready;
  assign unused_bits = ^{offset[63:IDX_W+3], offset[2:0]};

`ifdef YSYX_22050612_MEM_RAND_LAT_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign load_cnt = CNT_W'(LATENCY) + CNT_W'(lfsr[1:0]);
`else
  assign load_cnt = CNT_W'(LATENCY);
`endif

  always_ff @(posedge clk) begin
    if (access && wen_q && in_range) begin
      for (int i = 0; i < 8; i++) begin
        if (wmask_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      counter       <= '0;
      wen_q         <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wmask_q       <= '0;
      bus.req_ready <= 1'b0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            wen_q         <= bus.req_wen;
            addr_q        <= bus.req_addr;
            wdata_q       <= bus.req_wdata;
            wmask_q       <= bus.req_wmask;
            counter       <= load_cnt;
            bus.req_ready <= 1'b0;
            state         <= WAIT;
          end else begin
            bus.req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (counter != '0) begin
            counter <= counter - CNT_W'(1);
          end else begin
            bus.rsp_valid <= 1'b1;
            state         <= RESP;
            if (!in_range) begin
              bus.rsp_rdata <= '0;
              bus.rsp_err   <= 1'b1;
            end else begin
              bus.rsp_rdata <= wen_q ? 64'd0 : mem[idx];
              bus.rsp_err   <= 1'b0;
            end
          end
        end
        RESP: begin
          // req_ready rises with the handshake, so the next accept is one cycle later.
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            bus.req_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_22050612_mem_responder.sv
// tb/tb_ysyx_22050612_mem_responder.sv - directed self-checking bench for the memory responder
module tb_ysyx_22050612_mem_responder;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        use_b = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_wen = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wmask = '0;
  logic        rsp_ready = 1'b1;

  ysyx_22050612_mem_responder_if bus_a();
  ysyx_22050612_mem_responder_if bus_b();

  assign bus_a.req_valid = req_valid & ~use_b;
  assign bus_b.req_valid = req_valid & use_b;
  assign bus_a.req_wen   = req_wen;
  assign bus_b.req_wen   = req_wen;
  assign bus_a.req_addr  = req_addr;
  assign bus_b.req_addr  = req_addr;
  assign bus_a.req_wdata = req_wdata;
  assign bus_b.req_wdata = req_wdata;
  assign bus_a.req_wmask = req_wmask;
  assign bus_b.req_wmask = req_wmask;
  assign bus_a.rsp_ready = rsp_ready;
  assign bus_b.rsp_ready = rsp_ready;

  logic        cur_req_ready;
  logic        cur_rsp_valid;
  logic [63:0] cur_rsp_rdata;
  logic        cur_rsp_err;
  assign cur_req_ready = use_b ? bus_b.req_ready : bus_a.req_ready;
  assign cur_rsp_valid = use_b ? bus_b.rsp_valid : bus_a.rsp_valid;
  assign cur_rsp_rdata = use_b ? bus_b.rsp_rdata : bus_a.rsp_rdata;
  assign cur_rsp_err   = use_b ? bus_b.rsp_err   : bus_a.rsp_err;

  ysyx_22050612_mem_responder #(.DEPTH(1024), .BASE_ADDR(64'h80000000), .LATENCY(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave)
  );
  ysyx_22050612_mem_responder #(.DEPTH(1024), .BASE_ADDR(64'h80000000), .LATENCY(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave)
  );

  // Issues one request with rsp_ready high; lat = edges from acceptance until rsp_valid is seen.
  task automatic txn(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                     input logic [7:0] wmask, output logic [63:0] rdata, output logic err,
                     output int lat);
    int k;
    k = 0;
    while (cur_req_ready !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata; req_wmask = wmask;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (cur_rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rdata = cur_rsp_rdata;
    err = cur_rsp_err;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    use_b = 1'b0; rsp_ready = 1'b1; req_valid = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus_a.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", bus_a.req_ready); end
    checks++; if (bus_b.req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready_b: got %b expected 0", bus_b.req_ready); end
    checks++; if (bus_a.rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b expected 0", bus_a.rsp_valid); end
    checks++; if (bus_a.rsp_rdata !== 64'd0) begin errors++; $display("FAIL rst_rsp_rdata: got %h expected 0", bus_a.rsp_rdata); end
    checks++; if (bus_a.rsp_err !== 1'b0) begin errors++; $display("FAIL rst_rsp_err: got %b expected 0", bus_a.rsp_err); end
    rst_n = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (bus_a.req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b expected 1", bus_a.req_ready); end
  endtask

  task automatic test_write_read();
    logic [63:0] rd; logic er; int lat;
    use_b = 1'b0;
    txn(1'b1, 64'h80000010, 64'h1122334455667788, 8'hFF, rd, er, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL wr_latency: got %0d expected 3", lat); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL wr_rdata: got %h expected 0", rd); end
    checks++; if (er !== 1'b0) begin errors++; $display("FAIL wr_err: got %b expected 0", er); end
    checks++; if (cur_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_consumed: got %b expected 0", cur_rsp_valid); end
    checks++; if (cur_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready_after: got %b expected 1", cur_req_ready); end
    txn(1'b0, 64'h80000010, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h1122334455667788) begin errors++; $display("FAIL raw_rdata: got %h expected 1122334455667788", rd); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL rd_latency: got %0d expected 3", lat); end
  endtask

  task automatic test_byte_mask();
    logic [63:0] rd; logic er; int lat;
    use_b = 1'b0;
    txn(1'b1, 64'h80000010, 64'h0000AB0000000000, 8'h20, rd, er, lat);
    txn(1'b0, 64'h80000010, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h1122AB4455667788) begin errors++; $display("FAIL mask_byte5: got %h expected 1122ab4455667788", rd); end
    txn(1'b1, 64'h80000010, 64'hFFFFFFFFFFFFFFFF, 8'h00, rd, er, lat);
    checks++; if (lat !== 3 || er !== 1'b0) begin errors++; $display("FAIL mask_zero_rsp: got lat %0d err %b expected lat 3 err 0", lat, er); end
    txn(1'b0, 64'h80000010, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h1122AB4455667788) begin errors++; $display("FAIL mask_zero_unchanged: got %h expected 1122ab4455667788", rd); end
    txn(1'b0, 64'h80000017, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h1122AB4455667788) begin errors++; $display("FAIL low_bits_ignored: got %h expected 1122ab4455667788", rd); end
  endtask

  task automatic test_error();
    logic [63:0] rd; logic er; int lat;
    use_b = 1'b0;
    txn(1'b1, 64'h80000000, 64'h0123456789ABCDEF, 8'hFF, rd, er, lat);
    txn(1'b0, 64'h7FFFFFF8, 64'd0, 8'h00, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_below_err: got %b expected 1", er); end
    checks++; if (rd !== 64'd0) begin errors++; $display("FAIL err_below_rdata: got %h expected 0", rd); end
    txn(1'b1, 64'h80002000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, rd, er, lat);
    checks++; if (er !== 1'b1) begin errors++; $display("FAIL err_above_err: got %b expected 1", er); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL err_latency: got %0d expected 3", lat); end
    txn(1'b1, 64'h80001FF8, 64'hA5A5A5A55A5A5A5A, 8'hFF, rd, er, lat);
    txn(1'b0, 64'h80001FF8, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'hA5A5A5A55A5A5A5A || er !== 1'b0) begin errors++; $display("FAIL last_word: got %h err %b expected a5a5a5a55a5a5a5a err 0", rd, er); end
    txn(1'b0, 64'h80000000, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h0123456789ABCDEF || er !== 1'b0) begin errors++; $display("FAIL word0_after_err: got %h err %b expected 0123456789abcdef err 0", rd, er); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd; logic er; int lat; int k;
    use_b = 1'b0;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h80000010; req_wdata = '0; req_wmask = 8'h00;
    @(posedge clk); #1;
    req_wen = 1'b1; req_wdata = 64'd0; req_wmask = 8'hFF;
    k = 0;
    while (cur_rsp_valid !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
    checks++; if (k !== 3) begin errors++; $display("FAIL bp_latency: got %0d expected 3", k); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      checks++; if (cur_rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_hold: got %b expected 1", cur_rsp_valid); end
      checks++; if (cur_rsp_rdata !== 64'h1122AB4455667788) begin errors++; $display("FAIL bp_rdata_hold: got %h expected 1122ab4455667788", cur_rsp_rdata); end
      checks++; if (cur_req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready: got %b expected 0", cur_req_ready); end
    end
    req_addr = 64'h80000030; req_wdata = 64'h0BADCAFE00C0FFEE;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (cur_rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b expected 0", cur_rsp_valid); end
    checks++; if (cur_req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b expected 1", cur_req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++; if (cur_req_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept: got %b expected 0", cur_req_ready); end
    lat = 0;
    while (cur_rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat !== 3) begin errors++; $display("FAIL bp_next_latency: got %0d expected 3", lat); end
    @(posedge clk); #1;
    txn(1'b0, 64'h80000010, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h1122AB4455667788) begin errors++; $display("FAIL bp_ignored_write: got %h expected 1122ab4455667788", rd); end
    txn(1'b0, 64'h80000030, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h0BADCAFE00C0FFEE) begin errors++; $display("FAIL bp_accepted_write: got %h expected 0badcafe00c0ffee", rd); end
  endtask

  task automatic test_reset_mid_op();
    logic [63:0] rd; logic er; int lat; logic seen;
    use_b = 1'b1;
    @(posedge clk); #1;
    txn(1'b1, 64'h80000020, 64'h5, 8'hFF, rd, er, lat);
    checks++; if (lat !== 5) begin errors++; $display("FAIL lat4_latency: got %0d expected 5", lat); end
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 64'h80000020; req_wdata = 64'hFFFFFFFFFFFFFFFF; req_wmask = 8'hFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b0) begin errors++; $display("FAIL midop_in_reset: got valid %b ready %b expected 0 0", cur_rsp_valid, cur_req_ready); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (cur_rsp_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL midop_no_response: got %b expected 0", seen); end
    checks++; if (cur_req_ready !== 1'b1) begin errors++; $display("FAIL midop_ready: got %b expected 1", cur_req_ready); end
    txn(1'b0, 64'h80000020, 64'd0, 8'h00, rd, er, lat);
    checks++; if (rd !== 64'h5 || er !== 1'b0) begin errors++; $display("FAIL midop_dropped_write: got %h err %b expected 5 err 0", rd, er); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_mask();
    test_error();
    test_backpressure();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
